// File: rtl/subleq_pkg.sv
// subleq_pkg: shared constants and the command record used by the memory
// arbiter and its requesters.
//   MEM_READ / MEM_WRITE     : encoding of the RAM mem_op line
//   PORT_CPU / PORT_LOADER   : requester port numbers
//   DEFAULT_CONSOLE_ADDR     : default console tap address
//   mem_cmd_t                : one accepted memory command
package subleq_pkg;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam logic PORT_CPU    = 1'b0;
    localparam logic PORT_LOADER = 1'b1;

    localparam logic [63:0] DEFAULT_CONSOLE_ADDR = 64'hff;

    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        port;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/grant/response bundle for both arbiter ports.
//   reqN, weN, addrN, wdataN : request side, driven by requester N
//   gntN                     : combinational accept from the arbiter
//   rvalidN                  : registered one-cycle read-valid pulse
//   rdata                    : shared read data, qualified by rvalidN
// modport master = requester side, modport slave = arbiter side.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);

    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata
    );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker.
//   req[1:0] : requests
//   last     : port granted most recently
//   force1   : port 1 wins any contest (boot phase)
//   gnt[1:0] : one-hot grant, zero when nothing requests
module rr_arb2
    import subleq_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       force1,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
                // Contested: the port that did not win last time goes next.
                if (force1 || (last == PORT_CPU)) gnt = 2'b10;
                else                              gnt = 2'b01;
            end
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one negedge-sampled single-port RAM between the SUBLEQ
// cpu (port 0) and the loader/debug host (port 1).
//   clk, reset      : posedge clock, synchronous active-low reset
//   boot_done       : 0 = port 1 strict priority, 1 = round-robin
//   bus (slave)     : both request ports, grants, rvalids, shared rdata
//   mem_op, mem_addr, mem_write_bytes : registered RAM command
//   mem_data        : RAM read data
//   console_data, console_valid : present only with MEM_ARBITER_CONSOLE_TAP_EN;
//                     pulse on each accepted write to CONSOLE_ADDR
// A command is accepted at the posedge where reqN & gntN, the RAM acts on it
// at the following negedge, and read data is returned at the next posedge.
module mem_arbiter
    import subleq_pkg::*;
#(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
`ifdef MEM_ARBITER_CONSOLE_TAP_EN
    ,
    parameter logic [ADDR_W-1:0] CONSOLE_ADDR = ADDR_W'(DEFAULT_CONSOLE_ADDR)
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              boot_done,
    mem_arbiter_if.slave      bus,
    output logic              mem_op,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_bytes,
    input  logic [DATA_W-1:0] mem_data
`ifdef MEM_ARBITER_CONSOLE_TAP_EN
    ,
    output logic [DATA_W-1:0] console_data,
    output logic              console_valid
`endif
);

    logic [1:0]        req_v;
    logic [1:0]        gnt;
    logic              accept;
    mem_cmd_t          sel;

    logic              mem_op_q,      mem_op_d;
    logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
    logic [DATA_W-1:0] mem_wbytes_q,  mem_wbytes_d;
    logic              cmd_valid_q,   cmd_valid_d;
    logic              cmd_port_q,    cmd_port_d;
    logic              cmd_is_read_q, cmd_is_read_d;
    logic [1:0]        rvalid_q,      rvalid_d;
    logic [DATA_W-1:0] rdata_q,       rdata_d;
    logic              rr_last_q,     rr_last_d;
`ifdef MEM_ARBITER_CONSOLE_TAP_EN
    logic [DATA_W-1:0] console_data_q,  console_data_d;
    logic              console_valid_q, console_valid_d;
`endif

    // Gating requests with reset keeps both grants low while reset is held.
    assign req_v = {bus.req1, bus.req0} & {2{reset}};

    rr_arb2 u_arb (
        .req    (req_v),
        .last   (rr_last_q),
        .force1 (~boot_done),
        .gnt    (gnt)
    );

    assign bus.gnt0    = gnt[0];
    assign bus.gnt1    = gnt[1];
    assign bus.rvalid0 = rvalid_q[0];
    assign bus.rvalid1 = rvalid_q[1];
    assign bus.rdata   = rdata_q;

    assign mem_op          = mem_op_q;
    assign mem_addr        = mem_addr_q;
    assign mem_write_bytes = mem_wbytes_q;
`ifdef MEM_ARBITER_CONSOLE_TAP_EN
    assign console_data    = console_data_q;
    assign console_valid   = console_valid_q;
`endif

    always_comb begin
        accept = |gnt;
        if (gnt[1]) begin
            sel = '{we: bus.we1, addr: 64'(bus.addr1), wdata: 64'(bus.wdata1),
                    port: PORT_LOADER};
        end else begin
            sel = '{we: bus.we0, addr: 64'(bus.addr0), wdata: 64'(bus.wdata0),
                    port: PORT_CPU};
        end

        // Stage A: accept. When idle the RAM sees a harmless read of the
        // previous address.
        mem_op_d      = MEM_READ;
        mem_addr_d    = mem_addr_q;
        mem_wbytes_d  = mem_wbytes_q;
        cmd_valid_d   = 1'b0;
        cmd_port_d    = cmd_port_q;
        cmd_is_read_d = 1'b0;
        rr_last_d     = rr_last_q;
        if (accept) begin
            mem_op_d      = sel.we;
            mem_addr_d    = sel.addr[ADDR_W-1:0];
            mem_wbytes_d  = sel.wdata[DATA_W-1:0];
            cmd_valid_d   = 1'b1;
            cmd_port_d    = sel.port;
            cmd_is_read_d = (sel.we == MEM_READ);
            rr_last_d     = sel.port;
        end

        // Stage C: return data sampled by the RAM at the intervening negedge.
        rvalid_d = '0;
        rdata_d  = rdata_q;
        if (cmd_valid_q && cmd_is_read_q) begin
            rdata_d              = mem_data;
            rvalid_d[cmd_port_q] = 1'b1;
        end

`ifdef MEM_ARBITER_CONSOLE_TAP_EN
        console_valid_d = accept && (sel.we == MEM_WRITE) &&
                          (sel.addr[ADDR_W-1:0] == CONSOLE_ADDR);
        console_data_d  = console_valid_d ? sel.wdata[DATA_W-1:0] : console_data_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_op_q        <= MEM_READ;
            mem_addr_q      <= '0;
            mem_wbytes_q    <= '0;
            cmd_valid_q     <= 1'b0;
            cmd_port_q      <= PORT_CPU;
            cmd_is_read_q   <= 1'b0;
            rvalid_q        <= '0;
            rdata_q         <= '0;
            rr_last_q       <= PORT_LOADER;
`ifdef MEM_ARBITER_CONSOLE_TAP_EN
            console_data_q  <= '0;
            console_valid_q <= 1'b0;
`endif
        end else begin
            mem_op_q        <= mem_op_d;
            mem_addr_q      <= mem_addr_d;
            mem_wbytes_q    <= mem_wbytes_d;
            cmd_valid_q     <= cmd_valid_d;
            cmd_port_q      <= cmd_port_d;
            cmd_is_read_q   <= cmd_is_read_d;
            rvalid_q        <= rvalid_d;
            rdata_q         <= rdata_d;
            rr_last_q       <= rr_last_d;
`ifdef MEM_ARBITER_CONSOLE_TAP_EN
            console_data_q  <= console_data_d;
            console_valid_q <= console_valid_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed + random stimulus for mem_arbiter, with a
// negedge RAM and a transaction-level reference model in the bench.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        boot_done;
    logic        mem_op;
    logic [63:0] mem_addr;
    logic [63:0] mem_write_bytes;
    logic [63:0] mem_data;
`ifdef MEM_ARBITER_CONSOLE_TAP_EN
    logic [63:0] console_data;
    logic        console_valid;
`endif

    mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) ifc ();

    mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk             (clk),
        .reset           (reset),
        .boot_done       (boot_done),
        .bus             (ifc),
        .mem_op          (mem_op),
        .mem_addr        (mem_addr),
        .mem_write_bytes (mem_write_bytes),
        .mem_data        (mem_data)
`ifdef MEM_ARBITER_CONSOLE_TAP_EN
        ,
        .console_data    (console_data),
        .console_valid   (console_valid)
`endif
    );

    // RAM: acts on the registered command at each negedge.
    logic [63:0] ram [256];
    logic        ram_clr;
    always @(negedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) ram[i] <= '0;
            mem_data <= '0;
        end else if (mem_op) begin
            ram[mem_addr[7:0]] <= mem_write_bytes;
        end else begin
            mem_data <= ram[mem_addr[7:0]];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state (transaction level).
    logic [63:0] mdl_mem [256];
    logic        m_rr;          // port that won most recently
    logic        prev_rd;       // read accepted at the previous edge
    logic        prev_port;
    logic [63:0] prev_data;
    logic        e_op;
    logic [63:0] e_addr, e_wb, e_rdata;
    logic [1:0]  e_rv;
    logic        e_cv;
    logic [63:0] e_cd;
    logic [1:0]  obs_g;         // DUT grants seen in the last cycle

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check grants for the current inputs, let the edge happen,
    // update the model and check every registered output.
    task automatic cycle();
        logic [1:0]  g;
        logic        acc, p, w;
        logic [63:0] a, d;
        #1;
        g = 2'b00;
        if (reset) begin
            if (ifc.req0 && ifc.req1) g = !boot_done ? 2'b10 : (m_rr ? 2'b01 : 2'b10);
            else                      g = {ifc.req1, ifc.req0};
        end
        obs_g = {ifc.gnt1, ifc.gnt0};
        check("gnt0", 64'(ifc.gnt0), 64'(g[0]));
        check("gnt1", 64'(ifc.gnt1), 64'(g[1]));
        acc = |g;
        p   = g[1];
        w   = p ? ifc.we1    : ifc.we0;
        a   = p ? ifc.addr1  : ifc.addr0;
        d   = p ? ifc.wdata1 : ifc.wdata0;

        @(posedge clk);
        #1;
        if (!reset) begin
            m_rr = 1'b1; prev_rd = 1'b0; e_op = 1'b0; e_addr = '0; e_wb = '0;
            e_rdata = '0; e_rv = 2'b00; e_cv = 1'b0; e_cd = '0;
        end else begin
            e_rv = 2'b00;
            if (prev_rd) begin
                e_rv[prev_port] = 1'b1;
                e_rdata         = prev_data;
            end
            prev_rd = 1'b0;
            e_op    = 1'b0;
            e_cv    = 1'b0;
            if (acc) begin
                m_rr   = p;
                e_op   = w;
                e_addr = a;
                e_wb   = d;
                if (w) begin
                    mdl_mem[a[7:0]] = d;
                    if (a == 64'hff) begin e_cv = 1'b1; e_cd = d; end
                end else begin
                    prev_rd   = 1'b1;
                    prev_port = p;
                    prev_data = mdl_mem[a[7:0]];
                end
            end
        end
        check("mem_op",          64'(mem_op),      64'(e_op));
        check("mem_addr",        mem_addr,         e_addr);
        check("mem_write_bytes", mem_write_bytes,  e_wb);
        check("rvalid0",         64'(ifc.rvalid0), 64'(e_rv[0]));
        check("rvalid1",         64'(ifc.rvalid1), 64'(e_rv[1]));
        check("rdata",           ifc.rdata,        e_rdata);
`ifdef MEM_ARBITER_CONSOLE_TAP_EN
        check("console_valid",   64'(console_valid), 64'(e_cv));
        check("console_data",    console_data,       e_cd);
`endif
    endtask

    task automatic set_port(input int port, input logic rq, input logic we,
                            input logic [63:0] addr, input logic [63:0] wd);
        if (port == 0) begin
            ifc.req0 = rq; ifc.we0 = we; ifc.addr0 = addr; ifc.wdata0 = wd;
        end else begin
            ifc.req1 = rq; ifc.we1 = we; ifc.addr1 = addr; ifc.wdata1 = wd;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mdl_mem[i] = '0;
        m_rr = 1'b1; prev_rd = 1'b0; prev_port = 1'b0; prev_data = '0;
        e_op = 1'b0; e_addr = '0; e_wb = '0; e_rdata = '0; e_rv = 2'b00;
        e_cv = 1'b0; e_cd = '0; obs_g = 2'b00;
        ram_clr   = 1'b1;
        reset     = 1'b0;
        boot_done = 1'b0;
        set_port(0, 1'b1, 1'b0, 64'h0, 64'h0);
        set_port(1, 1'b1, 1'b0, 64'h0, 64'h0);

        // Reset hold with both requesting.
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("reset_gnt", 64'(obs_g), 64'(2'b00));
            ram_clr = 1'b0;
        end

        // Boot load: port 1 has strict priority over a held port 0 read.
        reset = 1'b1;
        set_port(0, 1'b1, 1'b0, 64'h10, 64'h0);
        for (int i = 0; i < 3; i++) begin
            set_port(1, 1'b1, 1'b1, 64'h10 + 64'(i), 64'hA0 + 64'(i));
            cycle();
            check("boot_gnt1", 64'(obs_g), 64'(2'b10));
        end
        set_port(1, 1'b0, 1'b0, 64'h0, 64'h0);
        cycle();
        check("boot_gnt0", 64'(obs_g), 64'(2'b01));
        set_port(0, 1'b0, 1'b0, 64'h0, 64'h0);
        cycle();
        check("boot_rdata", ifc.rdata, 64'hA0);
        cycle();
        check("ram_10", ram[8'h10], 64'hA0);
        check("ram_11", ram[8'h11], 64'hA1);
        check("ram_12", ram[8'h12], 64'hA2);

        // Round-robin from reset state: port 0 wins the first contest.
        reset = 1'b0;
        cycle();
        reset     = 1'b1;
        boot_done = 1'b1;
        set_port(0, 1'b1, 1'b0, 64'h11, 64'h0);
        set_port(1, 1'b1, 1'b0, 64'h12, 64'h0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("rr_seq", 64'(obs_g), (i % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
        end
        set_port(0, 1'b0, 1'b0, 64'h0, 64'h0);
        set_port(1, 1'b0, 1'b0, 64'h0, 64'h0);
        cycle();
        cycle();

        // Read-after-write on port 0.
        set_port(0, 1'b1, 1'b1, 64'h5, 64'hDEAD);
        cycle();
        set_port(0, 1'b1, 1'b0, 64'h5, 64'h0);
        cycle();
        set_port(0, 1'b0, 1'b0, 64'h0, 64'h0);
        cycle();
        check("raw_rvalid0", 64'(ifc.rvalid0), 64'h1);
        check("raw_rdata",   ifc.rdata,        64'hDEAD);

        // Reset while a port 1 read is in flight.
        set_port(1, 1'b1, 1'b0, 64'h12, 64'h0);
        cycle();
        set_port(1, 1'b0, 1'b0, 64'h0, 64'h0);
        reset = 1'b0;
        cycle();
        check("rst_rvalid1", 64'(ifc.rvalid1), 64'h0);
        check("rst_mem_op",  64'(mem_op),      64'h0);
        reset = 1'b1;
        cycle();
        check("rst_rvalid1_after", 64'(ifc.rvalid1), 64'h0);

`ifdef MEM_ARBITER_CONSOLE_TAP_EN
        // Console tap.
        set_port(0, 1'b1, 1'b1, 64'hFF, 64'h41);
        cycle();
        check("con_valid", 64'(console_valid), 64'h1);
        check("con_data",  console_data,       64'h41);
        set_port(0, 1'b1, 1'b1, 64'hFE, 64'h42);
        cycle();
        check("con_valid_fe", 64'(console_valid), 64'h0);
        set_port(0, 1'b0, 1'b0, 64'h0, 64'h0);
        cycle();
        check("con_valid_idle", 64'(console_valid), 64'h0);
`endif

        // Random traffic, with occasional resets and boot_done flips.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 19) == 0) boot_done = ~boot_done;
            for (int pt = 0; pt < 2; pt++) begin
                set_port(pt, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                         ($urandom_range(0, 9) == 0) ? 64'hFF : 64'($urandom_range(0, 15)),
                         {$urandom, $urandom});
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
